share_queue: RTL and testbench

- Sits directly downstream of the double-SHA finisher and directly upstream of the UART multibyte transmitter.
- Each cycle it tests the finisher's hash/nonce pair against a runtime difficulty (number of leading zero bits at the MSB end).
- Qualifying results ("shares") are suppressed if they repeat the last queued nonce, buffered in a small FIFO, and presented one at a time as a fully formatted 512-bit transmit message with a req/ready handshake.
- Shares that arrive while the FIFO is full are dropped and counted.

---
 rtl/share_queue.sv | 108 ++++++++++
 tb/tb_share_queue.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/share_queue.sv
// Share queue: filters finisher results against a leading-zero difficulty, drops repeat nonces,
// buffers shares in a small FIFO and presents the head entry as a 512-bit transmit message.
module share_queue #(
    parameter int          LOG_DEPTH = 2,
    parameter logic [63:0] MAGIC     = 64'hdead432987beefaa
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [255:0]         in_hash,
    input  logic [31:0]          in_nonce,
    input  logic [8:0]           zero_bits,
    output logic                 tx_req,
    input  logic                 tx_ready,
    output logic [511:0]         tx_data,
    output logic [LOG_DEPTH:0]   fifo_count,
    output logic [15:0]          drop_count
);

    localparam int                 DEPTH      = 2 ** LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH + 1)'(DEPTH);
    localparam logic [LOG_DEPTH:0] CNT_ONE    = (LOG_DEPTH + 1)'(1);
    localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);

    logic [255:0]          zero_mask;
    logic                  in_qual;

    logic                  s1_qual;
    logic [255:0]          s1_hash;
    logic [31:0]           s1_nonce;

    logic                  last_valid;
    logic [31:0]           last_nonce;

    logic [287:0]          mem [DEPTH];
    logic [LOG_DEPTH-1:0]  wr_ptr;
    logic [LOG_DEPTH-1:0]  rd_ptr;
    logic [287:0]          head;

    logic                  full;
    logic                  dup;
    logic                  want_push;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // Mask covers the top min(zero_bits, 256) hash bits; a zero-width mask qualifies everything.
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        if (zero_bits >= 9'd256) begin
            zero_mask = '1;
        end else begin
            zero_mask = ~({256{1'b1}} >> zero_bits[7:0]);
        end
        in_qual = in_valid && ((in_hash & zero_mask) == '0);
    end

    assign tx_req    = (fifo_count != '0);
    assign full      = (fifo_count == FULL_COUNT);
    assign pop       = tx_req && tx_ready;
    assign dup       = last_valid && (s1_nonce == last_nonce);
    assign want_push = s1_qual && !dup;
    assign push      = want_push && (!full || pop);
    assign drop      = want_push && full && !pop;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_qual    <= 1'b0;
            last_valid <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_count <= '0;
        end else begin
            s1_qual <= in_qual;
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_ONE;
                last_valid <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_ONE;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_ONE;
            end
            if (drop && (drop_count != 16'hffff)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // NOTE: payload storage is not reset; validity lives entirely in the reset-controlled pointers and flags.
    always_ff @(posedge clk) begin
        s1_hash  <= in_hash;
        s1_nonce <= in_nonce;
        if (push) begin
            mem[wr_ptr] <= {s1_nonce, s1_hash};
            last_nonce  <= s1_nonce;
        end
    end

    assign head    = mem[rd_ptr];
    assign tx_data = {MAGIC, 144'd0, 8'haa, head[287:256], 8'haa, head[255:0]};

endmodule

// File: tb/tb_share_queue.sv
// Bench for share_queue: qualification vector table plus hand sequences, with a cycle model
// whose scoreboard queue supplies the expected message on every handshake.
module tb_share_queue;

    localparam int          LOG_DEPTH = 2;
    localparam int          DEPTH     = 4;
    localparam logic [63:0] MAGIC     = 64'hdead432987beefaa;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic [255:0]         in_hash;
    logic [31:0]          in_nonce;
    logic [8:0]           zero_bits;
    logic                 tx_req;
    logic                 tx_ready;
    logic [511:0]         tx_data;
    logic [LOG_DEPTH:0]   fifo_count;
    logic [15:0]          drop_count;

    share_queue #(.LOG_DEPTH(LOG_DEPTH), .MAGIC(MAGIC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_hash    (in_hash),
        .in_nonce   (in_nonce),
        .zero_bits  (zero_bits),
        .tx_req     (tx_req),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .fifo_count (fifo_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] hash;
        logic [31:0]  nonce;
    } share_t;

    typedef struct {
        logic [8:0]   zb;
        logic [255:0] hash;
        logic [31:0]  nonce;
        bit           exp_qual;
    } vec_t;

    int     n_checks = 0;
    int     n_fail   = 0;

    share_t       sb_q[$];
    bit           m_on = 1'b0;
    bit           m_s1_qual = 1'b0;
    logic [31:0]  m_s1_nonce = '0;
    logic [255:0] m_s1_hash = '0;
    bit           m_last_valid = 1'b0;
    logic [31:0]  m_last_nonce = '0;
    int           m_drop = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit qualifies(input logic [255:0] h, input logic [8:0] zb);
        int k;
        k = (zb > 9'd256) ? 256 : int'(zb);
        for (int i = 0; i < k; i++) begin
            if (h[255 - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [511:0] fmt(input logic [255:0] h, input logic [31:0] n);
        return {MAGIC, 144'd0, 8'haa, n, 8'haa, h};
    endfunction

    function automatic logic [255:0] rand_hash();
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom();
        return h;
    endfunction

    // Advance the reference model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit pop;
        bit full;
        share_t s;
        if (!rst_n) begin
            sb_q.delete();
            m_s1_qual    = 1'b0;
            m_last_valid = 1'b0;
            m_drop       = 0;
            return;
        end
        pop  = tx_ready && (sb_q.size() != 0);
        full = (sb_q.size() == DEPTH);
        if (m_s1_qual && !(m_last_valid && (m_s1_nonce == m_last_nonce))) begin
            if (full && !pop) begin
                if (m_drop != 65535) m_drop++;
            end else begin
                s.hash  = m_s1_hash;
                s.nonce = m_s1_nonce;
                if (pop) void'(sb_q.pop_front());
                pop = 1'b0;
                sb_q.push_back(s);
                m_last_valid = 1'b1;
                m_last_nonce = m_s1_nonce;
            end
        end
        if (pop) void'(sb_q.pop_front());
        m_s1_qual  = in_valid && qualifies(in_hash, zero_bits);
        m_s1_hash  = in_hash;
        m_s1_nonce = in_nonce;
    endtask

    task automatic step();
        if (m_on) begin
            check("tx_req", 512'(tx_req), 512'(sb_q.size() != 0));
            check("fifo_count", 512'(fifo_count), 512'(sb_q.size()));
            check("drop_count", 512'(drop_count), 512'(m_drop));
            if (rst_n && tx_ready && (sb_q.size() != 0)) begin
                check("tx_data", tx_data, fmt(sb_q[0].hash, sb_q[0].nonce));
            end
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [8:0] zb, input logic [255:0] h,
                         input logic [31:0] n, input bit rdy);
        in_valid  = v;
        zero_bits = zb;
        in_hash   = h;
        in_nonce  = n;
        tx_ready  = rdy;
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 9'd0, '0, 32'd0, rdy);
    endtask

    vec_t         vecs[10];
    logic [255:0] h;
    logic [31:0]  order[4];

    initial begin
        vecs[0] = '{9'd24,  {24'h000001, 232'd0},       32'h1000_0000, 1'b0};
        vecs[1] = '{9'd0,   {256{1'b1}},                32'h1000_0001, 1'b1};
        vecs[2] = '{9'd300, 256'd0,                     32'h1000_0002, 1'b1};
        vecs[3] = '{9'd300, 256'd1,                     32'h1000_0003, 1'b0};
        vecs[4] = '{9'd256, 256'd0,                     32'h1000_0004, 1'b1};
        vecs[5] = '{9'd255, 256'd1,                     32'h1000_0005, 1'b1};
        vecs[6] = '{9'd255, 256'd2,                     32'h1000_0006, 1'b0};
        vecs[7] = '{9'd1,   {1'b1, 255'd0},             32'h1000_0007, 1'b0};
        vecs[8] = '{9'd1,   {1'b0, {255{1'b1}}},        32'h1000_0008, 1'b1};
        vecs[9] = '{9'd24,  {24'h0, {232{1'b1}}},       32'h1000_0009, 1'b1};

        rst_n = 1'b0;
        idle(1'b0);
        @(posedge clk);
        #1;
        m_on = 1'b1;
        step();
        rst_n = 1'b1;
        check("reset_tx_req", 512'(tx_req), 512'(0));
        check("reset_fifo_count", 512'(fifo_count), 512'(0));
        check("reset_drop_count", 512'(drop_count), 512'(0));

        // Basic share: latency, message fields, retire.
        h = {24'h0, 8'hff, {7{32'h5a5a1234}}};
        drive(1'b1, 9'd24, h, 32'hb2957c02, 1'b0);
        step();
        idle(1'b0);
        check("latency_1", 512'(tx_req), 512'(0));
        step();
        check("latency_2", 512'(tx_req), 512'(1));
        check("msg_nonce", 512'(tx_data[295:264]), 512'(32'hb2957c02));
        check("msg_sep", 512'(tx_data[263:256]), 512'(8'haa));
        check("msg_magic", 512'(tx_data[511:448]), 512'(MAGIC));
        check("msg_full", tx_data, {MAGIC, 144'd0, 8'haa, 32'hb2957c02, 8'haa, h});
        idle(1'b1);
        step();
        idle(1'b0);
        check("basic_drained", 512'(fifo_count), 512'(0));
        step();

        // Qualification table.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].zb, vecs[i].hash, vecs[i].nonce, 1'b0);
            step();
            idle(1'b0);
            step();
            step();
            check($sformatf("qual_%0d", i), 512'(fifo_count), 512'(vecs[i].exp_qual));
            if (vecs[i].exp_qual) begin
                idle(1'b1);
                step();
                idle(1'b0);
                step();
            end
        end

        // zero_bits=0 with valid held: every cycle queues.
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 9'd0, rand_hash(), 32'h2000_0000 + 32'(j), 1'b0);
            step();
        end
        idle(1'b0);
        step();
        step();
        check("zb0_every_cycle", 512'(fifo_count), 512'(3));
        idle(1'b1);
        repeat (3) step();
        idle(1'b0);
        step();

        // Duplicate nonce held for 10 cycles.
        h = rand_hash();
        drive(1'b1, 9'd0, h, 32'h3000_0001, 1'b0);
        repeat (10) step();
        idle(1'b0);
        step();
        step();
        check("dup_count", 512'(fifo_count), 512'(1));
        check("dup_drop", 512'(drop_count), 512'(0));
        drive(1'b1, 9'd0, h, 32'h3000_0002, 1'b0);
        step();
        idle(1'b0);
        step();
        step();
        check("dup_new_nonce", 512'(fifo_count), 512'(2));
        idle(1'b1);
        repeat (2) step();
        idle(1'b0);
        step();

        // Overflow: six shares into four slots.
        for (int j = 0; j < 6; j++) begin
            h = rand_hash();
            h[255:248] = 8'h00;
            drive(1'b1, 9'd8, h, 32'h4000_0000 + 32'(j), 1'b0);
            step();
        end
        idle(1'b0);
        step();
        step();
        check("ovf_count", 512'(fifo_count), 512'(4));
        check("ovf_drop", 512'(drop_count), 512'(2));

        // Push coinciding with pop while full.
        h = rand_hash();
        h[255:248] = 8'h00;
        drive(1'b1, 9'd8, h, 32'h4000_00aa, 1'b0);
        step();
        idle(1'b1);
        check("full_head", 512'(tx_data[295:264]), 512'(32'h4000_0000));
        step();
        idle(1'b0);
        check("full_pushpop_count", 512'(fifo_count), 512'(4));
        check("full_pushpop_drop", 512'(drop_count), 512'(2));
        step();
        order[0] = 32'h4000_0001;
        order[1] = 32'h4000_0002;
        order[2] = 32'h4000_0003;
        order[3] = 32'h4000_00aa;
        idle(1'b1);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("order_%0d", j), 512'(tx_data[295:264]), 512'(order[j]));
            step();
        end
        idle(1'b0);
        check("ovf_drained", 512'(fifo_count), 512'(0));
        step();

        // Reset while a handshake is pending.
        h = rand_hash();
        drive(1'b1, 9'd0, h, 32'h5000_0001, 1'b0);
        step();
        drive(1'b1, 9'd0, h, 32'h5000_0002, 1'b0);
        step();
        idle(1'b0);
        step();
        step();
        check("pre_reset_count", 512'(fifo_count), 512'(2));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_reset_tx_req", 512'(tx_req), 512'(0));
        check("mid_reset_count", 512'(fifo_count), 512'(0));
        check("mid_reset_drop", 512'(drop_count), 512'(0));
        drive(1'b1, 9'd0, h, 32'h5000_0002, 1'b0);
        step();
        idle(1'b0);
        step();
        step();
        check("no_dup_after_reset", 512'(fifo_count), 512'(1));
        idle(1'b1);
        step();
        idle(1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
